// File: rtl/mux_pipe_scan.sv
// Pipelined radix-4 tree multiplexer with valid/tag sideband
// and an internal wrapping channel-scan counter.
module mux_pipe_scan #(
  parameter int WIDTH = 1,
  parameter int SEL_W = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [(2**SEL_W)*WIDTH-1:0] w,
  input  logic [SEL_W-1:0]            s,
  input  logic                        mode,
  input  logic                        in_valid,
  output logic [WIDTH-1:0]            f,
  output logic                        out_valid,
  output logic [SEL_W-1:0]            out_ch,
  output logic                        out_last
);

  localparam int N = 2 ** SEL_W;
  localparam int L = (SEL_W + 1) / 2;

  function automatic int lvl_cnt(input int k);
    int b;
    b = 2 * (k + 1);
    if (b > SEL_W) b = SEL_W;
    return N >> b;
  endfunction

  function automatic int lvl_off(input int k);
    int o;
    o = 0;
    for (int j = 0; j < k; j++)
      o += lvl_cnt(j) * WIDTH;
    return o;
  endfunction

  localparam int TOT = lvl_off(L);

  logic [SEL_W-1:0] scan_cnt;
  logic [SEL_W-1:0] sel_e;
  logic             last_in;
  logic [TOT-1:0]   pool;
  logic [TOT-1:0]   nxt;
  logic [TOT-1:0]   en;
  logic             vld [L];
  logic             lst [L];
  logic [SEL_W-1:0] tag [L];

  assign sel_e   = mode ? scan_cnt : s;
  assign last_in = mode & (&scan_cnt);

  // All level registers live in one packed pool;
  // level k owns its slice and is loaded only when
  // its incoming sample is valid.
  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int RB  = (2*k + 1 < SEL_W) ? 2 : 1;
    localparam int OC  = lvl_cnt(k);
    localparam int IC  = OC << RB;
    localparam int OFF = lvl_off(k);

    logic [IC*WIDTH-1:0] src;
    logic [RB-1:0]       sk;
    logic                ld;

    if (k == 0) begin : g_in
      assign src = w;
      assign ld  = in_valid;
      assign sk  = sel_e[2*k +: RB];
    end else begin : g_in
      assign src = pool[lvl_off(k-1) +: IC*WIDTH];
      assign ld  = vld[k-1];
      assign sk  = tag[k-1][2*k +: RB];
    end

    for (genvar j = 0; j < OC; j++) begin : g_mux
      assign nxt[OFF + j*WIDTH +: WIDTH] =
        src[(j * (2**RB) + int'(sk)) * WIDTH +: WIDTH];
    end

    assign en[OFF +: OC*WIDTH] = {(OC*WIDTH){ld}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      pool     <= '0;
      for (int k = 0; k < L; k++) begin
        vld[k] <= 1'b0;
        lst[k] <= 1'b0;
        tag[k] <= '0;
      end
    end else begin
      if (in_valid && mode)
        scan_cnt <= scan_cnt + SEL_W'(1);
      pool   <= (nxt & en) | (pool & ~en);
      vld[0] <= in_valid;
      if (in_valid) begin
        tag[0] <= sel_e;
        lst[0] <= last_in;
      end
      for (int k = 1; k < L; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) begin
          tag[k] <= tag[k-1];
          lst[k] <= lst[k-1];
        end
      end
    end
  end

  assign f         = pool[lvl_off(L-1) +: WIDTH];
  assign out_valid = vld[L-1];
  assign out_ch    = tag[L-1];
  assign out_last  = lst[L-1];

endmodule

// File: tb/tb_mux_pipe_scan.sv
// Directed bench for mux_pipe_scan: SEL_W=4 (L=2)
// and SEL_W=5 (L=3) instances, WIDTH=8.
module tb_mux_pipe_scan;

  logic clk;
  logic reset;

  logic [16*8-1:0] w4;
  logic [3:0]      s4;
  logic            m4, iv4;
  logic [7:0]      f4;
  logic            v4, l4;
  logic [3:0]      ch4;

  logic [32*8-1:0] w5;
  logic [4:0]      s5;
  logic            m5, iv5;
  logic [7:0]      f5;
  logic            v5, l5;
  logic [4:0]      ch5;

  int n_run;
  int n_fail;

  int iv_q[$], md_q[$], s_q[$];
  int ev_q[$], ef_q[$], ec_q[$], el_q[$];

  mux_pipe_scan #(.WIDTH(8), .SEL_W(4)) dut4 (
    .clk(clk), .reset(reset), .w(w4), .s(s4),
    .mode(m4), .in_valid(iv4), .f(f4),
    .out_valid(v4), .out_ch(ch4), .out_last(l4)
  );

  mux_pipe_scan #(.WIDTH(8), .SEL_W(5)) dut5 (
    .clk(clk), .reset(reset), .w(w5), .s(s5),
    .mode(m5), .in_valid(iv5), .f(f5),
    .out_valid(v5), .out_ch(ch5), .out_last(l5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit big, input int i,
                       input int m, input int sv);
    if (big) begin
      iv5 = 1'(i);
      m5  = 1'(m);
      s5  = 5'(sv);
      iv4 = 1'b0;
    end else begin
      iv4 = 1'(i);
      m4  = 1'(m);
      s4  = 4'(sv);
      iv5 = 1'b0;
    end
  endtask

  task automatic clr();
    iv_q.delete(); md_q.delete(); s_q.delete();
    ev_q.delete(); ef_q.delete();
    ec_q.delete(); el_q.delete();
  endtask

  task automatic push(input int i, input int m,
                      input int sv, input int ev,
                      input int ef, input int ec,
                      input int el);
    iv_q.push_back(i);
    md_q.push_back(m);
    s_q.push_back(sv);
    ev_q.push_back(ev);
    ef_q.push_back(ef);
    ec_q.push_back(ec);
    el_q.push_back(el);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    iv4 = 1'b1; m4 = 1'b1;
    iv5 = 1'b1; m5 = 1'b1;
    cyc();
    reset = 1'b0;
    iv4 = 1'b0;
    iv5 = 1'b0;
  endtask

  task automatic run(input bit big, input string nm);
    int lat;
    int nt;
    lat = big ? 3 : 2;
    nt  = iv_q.size();
    for (int t = 0; t < nt + lat - 1; t++) begin
      if (t < nt)
        drive(big, iv_q[t], md_q[t], s_q[t]);
      else
        drive(big, 0, 0, 0);
      cyc();
      if (t >= lat - 1) begin
        int i;
        i = t - lat + 1;
        chk($sformatf("%s[%0d].valid", nm, i),
            big ? 32'(v5) : 32'(v4), ev_q[i]);
        chk($sformatf("%s[%0d].f", nm, i),
            big ? 32'(f5) : 32'(f4), ef_q[i]);
        chk($sformatf("%s[%0d].ch", nm, i),
            big ? 32'(ch5) : 32'(ch4), ec_q[i]);
        chk($sformatf("%s[%0d].last", nm, i),
            big ? 32'(l5) : 32'(l4), el_q[i]);
      end
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b0;
    s4 = '0; m4 = 1'b0; iv4 = 1'b0;
    s5 = '0; m5 = 1'b0; iv5 = 1'b0;
    for (int i = 0; i < 16; i++)
      w4[i*8 +: 8] = 8'hA0 + 8'(i);
    for (int i = 0; i < 32; i++)
      w5[i*8 +: 8] = 8'h3D + 8'(i);
    cyc();

    do_reset();
    chk("rst4.valid", 32'(v4), 0);
    chk("rst4.f", 32'(f4), 0);
    chk("rst4.ch", 32'(ch4), 0);
    chk("rst4.last", 32'(l4), 0);
    chk("rst5.valid", 32'(v5), 0);
    chk("rst5.f", 32'(f5), 0);
    chk("rst5.ch", 32'(ch5), 0);
    chk("rst5.last", 32'(l5), 0);

    clr();
    push(1, 0, 9, 1, 'hA9, 9, 0);
    push(0, 0, 0, 0, 'hA9, 9, 0);
    run(0, "manual");

    do_reset();
    clr();
    for (int i = 0; i < 18; i++)
      push(1, 1, 0, 1, 'hA0 + i % 16, i % 16,
           int'(i % 16 == 15));
    run(0, "sweep");

    do_reset();
    clr();
    push(1, 1, 0, 1, 'hA0, 0, 0);
    push(0, 1, 0, 0, 'hA0, 0, 0);
    push(1, 1, 0, 1, 'hA1, 1, 0);
    push(1, 1, 0, 1, 'hA2, 2, 0);
    push(0, 1, 0, 0, 'hA2, 2, 0);
    run(0, "bubble");

    do_reset();
    clr();
    for (int i = 0; i < 5; i++)
      push(1, 1, 0, 1, 'hA0 + i, i, 0);
    for (int i = 0; i < 3; i++)
      push(1, 0, 12, 1, 'hAC, 12, 0);
    push(1, 1, 0, 1, 'hA5, 5, 0);
    run(0, "modesw");

    do_reset();
    drive(0, 1, 1, 0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(0, 0, 1, 0);
    chk("midrst.valid", 32'(v4), 0);
    chk("midrst.f", 32'(f4), 0);
    chk("midrst.ch", 32'(ch4), 0);
    chk("midrst.last", 32'(l4), 0);
    clr();
    push(0, 1, 0, 0, 0, 0, 0);
    push(0, 1, 0, 0, 0, 0, 0);
    push(1, 1, 0, 1, 'hA0, 0, 0);
    run(0, "postrst");

    do_reset();
    clr();
    push(1, 0, 31, 1, 'h5C, 31, 0);
    push(0, 0, 0, 0, 'h5C, 31, 0);
    run(1, "odd_manual");

    do_reset();
    clr();
    for (int i = 0; i < 33; i++)
      push(1, 1, 0, 1, 'h3D + i % 32, i % 32,
           int'(i % 32 == 31));
    run(1, "odd_sweep");

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_pipe_scan.md
# mux_pipe_scan

Parametrised, pipelined 2^SEL_W-to-1 multiplexer for WIDTH-bit channels, built as a registered radix-4 tree, with per-sample valid tracking and a channel tag on every output. A built-in scan mode steps through all channels automatically with a wrapping counter, without an external select driver. Sits between multi-channel sources (sensor/port banks) and a single downstream consumer that needs a time-multiplexed stream.

## Interface
- WIDTH, 1: data bits per channel
- SEL_W, 4: select width; channel count N = 2^SEL_W (SEL_W >= 1)
- clk  input  1  rising-edge clock; only clock
- reset  input  1  synchronous, active-high reset
- w  input  N*WIDTH  channel data; channel i = w[i*WIDTH +: WIDTH]
- s  input  SEL_W  manual select; used when mode=0
- mode  input  1  0 = manual (select from s), 1 = scan (select from internal counter)
- in_valid  input  1  sample w and the effective select this cycle
- f  output  WIDTH  selected channel data, registered
- out_valid  output  1  f/out_ch/out_last carry a valid sample
- out_ch  output  SEL_W  channel index that produced f
- out_last  output  1  sample came from scan mode with channel N-1 (end of sweep)

## Operation
- Levels: L = ceil(SEL_W/2). Level k (k = 0..L-1) is a bank of 4:1 muxes on select bits [2k+1:2k]; if SEL_W odd, the final level is 2:1 on bit SEL_W-1. Each level output is registered.
- Effective select sel_e = (mode ? scan_cnt : s), sampled in the in_valid cycle.
- In the accepting cycle, level 0 muxes w directly; only w, s, mode are required stable in that cycle.
- Remaining select bits, sel_e (as tag), valid bit and last flag travel alongside the data through every pipeline register; no combinational path from inputs to outputs.
- scan_cnt: SEL_W-bit counter, reset 0. Increments by 1 each cycle with in_valid=1 and mode=1; wraps N-1 -> 0. Holds otherwise (including while mode=0). Not cleared by mode changes.
- Last flag = mode & in_valid & (scan_cnt == N-1), captured in accepting cycle.
- No backpressure: pipeline always advances; in_valid=0 cycles create bubbles (out_valid=0 L cycles later).
- When out_valid=0, f/out_ch/out_last hold their previous values (registers enabled by the valid bit); out_last is only meaningful with out_valid=1.

## Timing
- Latency: sample accepted at edge t appears at outputs after edge t+L-1 (i.e. visible in cycle t+L relative to acceptance cycle t); L=2 for SEL_W=4, L=3 for SEL_W=5/6.
- Throughput: one sample per cycle, back-to-back.
- Reset: on a clock edge with reset=1, all valid bits, data, tags, f=0, out_ch=0, out_valid=0, out_last=0, scan_cnt=0. In-flight samples discarded; in_valid during reset ignored.
- After reset deasserts, first out_valid occurs L cycles after first accepted in_valid.
- Mode switch takes effect on the same cycle's sample; samples already in flight keep their original tag.
- mode=1 with in_valid=1 on the cycle scan_cnt=N-1: that sample tagged out_ch=N-1, out_last=1; next scan sample tagged channel 0.

## Test plan
- Manual select (WIDTH=8, SEL_W=4): w channel i = 8'hA0+i, s=4'd9, in_valid=1 one cycle -> exactly 2 cycles later out_valid=1, f=8'hA9, out_ch=9, out_last=0; then out_valid=0.
- Scan sweep: mode=1, in_valid=1 for 18 cycles after reset -> out_ch 0,1,…,15,0,1 on consecutive cycles, f matches channel, out_last=1 only on out_ch=15.
- Bubbles and hold: scan with in_valid pattern 1,0,1,1,0 -> out_valid pattern delayed by 2, out_ch 0,–,1,2,–; scan_cnt not advanced on bubbles; f holds on bubble cycles.
- Mode switch mid-scan: scan 5 samples (ch 0-4), 3 manual samples s=12, scan again -> outputs 0,1,2,3,4,12,12,12,5; out_last=0 throughout.
- Reset mid-flight: in_valid=1 for 2 cycles then reset=1 one cycle -> no out_valid for discarded samples; all outputs 0; next scan sample tagged ch 0.
- Odd depth (WIDTH=8, SEL_W=5, L=3): manual s=5'd31, channel 31 = 8'h5C -> f=8'h5C, out_ch=31 after 3 cycles; full 32-channel scan back-to-back produces out_last on ch 31 only.
